// File: rtl/arith_cmd_pkg.sv
// Shared types and constants for the arithmetic command engine and its datapath.
package arith_cmd_pkg;

    typedef enum logic [2:0] {
        HDR,
        OPS,
        CALC,
        TX_HI,
        TX_LO
    } state_t;

    typedef enum logic [1:0] {
        MODE_SUM_PROD = 2'd0,
        MODE_DOT      = 2'd1,
        MODE_XOR_MASK = 2'd2,
        MODE_MIX      = 2'd3
    } mode_t;

    localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;
    localparam int         NUM_OPS             = 5;

endpackage

// File: rtl/arith_cmd_if.sv
// Byte-stream link: command bytes into the engine, result bytes out of it.
interface arith_cmd_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    // Link side: issues command bytes and collects result bytes.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/arith_mode_unit.sv
// Combinational four-mode arithmetic datapath; every result is truncated to 16 bits.
module arith_mode_unit
    import arith_cmd_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    input  logic [7:0]  d,
    input  logic [7:0]  e,
    input  mode_t       mode,
    output logic [15:0] result
);

    logic [8:0]  s_ab, s_cd;
    logic [15:0] m1, m2, m3, m4, x_bd;

    // The operand sums keep their carry bit before the multiply.
    assign s_ab = {1'b0, a} + {1'b0, b};
    assign s_cd = {1'b0, c} + {1'b0, d};

    assign m1   = 16'(s_ab) * 16'(s_cd);
    assign m2   = 16'(a) * 16'(c) + 16'(b) * 16'(d);
    assign x_bd = 16'(a ^ b) + 16'(d);
    assign m3   = x_bd * 16'(e & 8'h0F);
    assign m4   = (m1 + m2) ^ (m3 >> 2);

    always_comb begin
        result = m1;
        case (mode)
            MODE_SUM_PROD: result = m1;
            MODE_DOT:      result = m2;
            MODE_XOR_MASK: result = m3;
            MODE_MIX:      result = m4;
            default:       result = m1;
        endcase
    end

endmodule

// File: rtl/arith_cmd_engine.sv
// Sequencer: collects a header and five operands, computes once, returns result high byte then low byte.
module arith_cmd_engine
    import arith_cmd_pkg::*;
#(
    parameter logic [3:0] SYNC_NIBBLE = SYNC_NIBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    arith_cmd_if.slave  bus,
    output logic        busy,
    output logic [7:0]  err_count
);

    state_t      state, state_nx;
    mode_t       mode;
    logic [2:0]  cnt;
    logic [7:0]  ops [NUM_OPS];
    logic [15:0] result, calc;
    logic        hdr_ok;
    logic        in_ready_c, out_valid_c;
    logic [7:0]  out_data_c;

    assign hdr_ok = (bus.in_data[7:4] == SYNC_NIBBLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= HDR;
        else     state <= state_nx;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = 8'h00;
        case (state)
            HDR: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && hdr_ok) state_nx = OPS;
            end
            OPS: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && cnt == 3'(NUM_OPS - 1)) state_nx = CALC;
            end
            CALC: state_nx = TX_HI;
            TX_HI: begin
                out_valid_c = 1'b1;
                out_data_c  = result[15:8];
                if (bus.out_ready) state_nx = TX_LO;
            end
            TX_LO: begin
                out_valid_c = 1'b1;
                out_data_c  = result[7:0];
                if (bus.out_ready) state_nx = HDR;
            end
            default: state_nx = HDR;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
    assign busy          = (state != HDR);

    // NOTE: the operand file is cleared on reset so an aborted command leaves nothing stale behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 3'd0;
            mode      <= MODE_SUM_PROD;
            result    <= 16'h0000;
            err_count <= 8'h00;
            for (int i = 0; i < NUM_OPS; i++) ops[i] <= 8'h00;
        end else begin
            case (state)
                HDR: if (bus.in_valid) begin
                    if (hdr_ok) begin
                        mode <= mode_t'(bus.in_data[1:0]);
                        cnt  <= 3'd0;
                    end else if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                OPS: if (bus.in_valid) begin
                    ops[cnt] <= bus.in_data;
                    cnt      <= cnt + 3'd1;
                end
                CALC:    result <= calc;
                default: ;
            endcase
        end
    end

    arith_mode_unit u_mode_unit (
        .a      (ops[0]),
        .b      (ops[1]),
        .c      (ops[2]),
        .d      (ops[3]),
        .e      (ops[4]),
        .mode   (mode),
        .result (calc)
    );

endmodule

// File: doc/arith_cmd_engine.md
# arith_cmd_engine

- Byte-stream front end for the four-mode arithmetic function.
- Receives a command as a header byte plus five operand bytes on a valid/ready input stream and computes the selected 16-bit result.
- Returns the result as two bytes, high then low, on a valid/ready output stream.
- Sits between the command link and the arithmetic datapath. It is the issuing/collecting end of the unit's operand/result interface.

## Interface
Parameters:
- SYNC_NIBBLE, 4'hA, required value of header bits [7:4]

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input byte valid
- in_data  input  8  input byte
- in_ready  output  1  engine accepts byte this cycle
- out_valid  output  1  result byte valid
- out_data  output  8  result byte
- out_ready  input  1  downstream accepts byte
- busy  output  1  high in every state except HDR
- err_count  output  8  saturating count of rejected headers

## Operation
- A byte transfers when valid && ready in the same cycle, on either stream.
- Header byte format:
  - [7:4] must equal SYNC_NIBBLE. Otherwise the byte is consumed and dropped, err_count increments (saturates at 255), and the engine stays in HDR.
  - [3:2] are reserved and ignored.
  - [1:0] is mode.
- Operand bytes follow the header in order a, b, c, d, e.
- All arithmetic is performed at 16 bits, and each result is truncated mod 2^16:
  - m1 = (a+b)*(c+d). The sums keep their 9th bit.
  - m2 = a*c + b*d.
  - m3 = ((a^b)+d) * (e & 8'h0F).
  - m4 = (m1+m2) ^ (m3>>2). The shift is applied to the truncated 16-bit m3.
  - result = m1, m2, m3 or m4 for mode 0, 1, 2, 3 respectively.
- State machine:
  - HDR: in_ready=1. A valid header moves to OPS with cnt=0.
  - OPS: in_ready=1. Each accepted byte is stored to operand[cnt]. Accepting the byte at cnt==4 moves to CALC.
  - CALC: in_ready=0. Result is registered; moves to TX_HI unconditionally.
  - TX_HI: out_valid=1, out_data=result[15:8]. On handshake, moves to TX_LO.
  - TX_LO: out_valid=1, out_data=result[7:0]. On handshake, moves to HDR.
- One command is in flight at a time. in_ready=0 in CALC, TX_HI and TX_LO, so there is no overlap with the next command.
- in_valid deasserting in OPS only stalls the engine. There is no timeout, and partial operands are held.

## Timing
- Reset values: state HDR, in_ready=1, out_valid=0, out_data=0, busy=0, err_count=0, operands and result=0.
- rst mid-command discards partial operands and any pending result. err_count is also cleared. in_ready=1 in the first cycle after rst deasserts.
- Latency: if the last operand (e) is accepted at edge N, out_valid rises after edge N+1 (one CALC cycle).
- out_data and out_valid hold stable while out_valid && !out_ready.
- If the low byte is accepted at edge M, in_ready=1 from edge M. Minimum command period is 6 + 1 + 2 = 9 cycles.
- An invalid header costs one cycle. The next byte is evaluated as a header.
- Simultaneous rst and a handshake: rst wins and the transfer is dropped.

## Structure
Shared package arith_cmd_pkg contains:
- state enum {HDR, OPS, CALC, TX_HI, TX_LO}
- mode constants MODE_SUM_PROD=0, MODE_DOT=1, MODE_XOR_MASK=2, MODE_MIX=3
- the default SYNC_NIBBLE

Sub-module:
- The combinational datapath is split out as arith_mode_unit: a..e, mode in; 16-bit result out.
- The sequencer (FSM, operand registers, counter, output mux) stays in arith_cmd_engine.

## Test plan
- Header 0xA0, then a=3 b=5 c=7 d=2 e=0x1F; repeat with headers 0xA1, 0xA2, 0xA3. Output byte pairs must be 0x00 0x48, 0x00 0x1F, 0x00 0x78, 0x00 0x79.
- Header 0xA0 with all operands 0xFF must return 0xF8 0x04 (wrap-around). Header 0xAC (reserved bits set) with the same operands must return the same result.
- Header 0x50, then a valid command. The bad byte is dropped, err_count=1, and the valid command returns its correct result. Sending 300 bad headers leaves err_count=255.
- Hold out_ready=0 for 5 cycles after out_valid rises. out_data must stay at the high byte and in_ready must stay 0. Releasing out_ready gives high then low in consecutive cycles.
- Assert rst after 3 operands. After reset, outputs are at reset values, and a full new command returns only its own result.
- Gap in_valid between operands, and drive in_valid during TX. Operands must not be corrupted, and no byte may be accepted while in_ready=0.
